uart_reg_bridge: RTL and testbench

Parametrised byte-stream-to-register-bus bridge for the UART control path. It sits between the UART receiver/transmitter byte interfaces and a block's register file. It decodes framed read/write commands with burst length and address auto-increment, and buffers read responses in a TX FIFO. It also detects inter-byte timeouts, out-of-range addresses and RX overruns, and reports them through sticky error flags.

---
 rtl/uart_reg_bridge_if.sv | 26 ++
 rtl/uart_reg_bridge.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_bridge_if.sv
// Byte-stream and register-bus signals of the UART register bridge.
// The bridge takes the master view; the UART byte ports and the register file sit on the slave side.
interface uart_reg_bridge_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, reg_rdata,
        output tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, reg_rdata,
        input  tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// Decodes framed read/write bursts from a UART byte stream into register strobes.
// Read responses are queued in a TX FIFO, and error conditions are reported through sticky flags.
module uart_reg_bridge #(
    parameter int         ADDR_W      = 3,
    parameter int         NREGS       = 8,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         TIMEOUT_CYC = 10000,
    parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_reg_bridge_if.master bus,
    output logic              busy,
    output logic              err_addr,
    output logic              err_timeout,
    output logic              err_overrun,
    input  logic              err_clr,
    output logic              irq
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_WDATA,
        S_RD_REQ,
        S_RD_CAP
    } state_t;

    state_t            state_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        cnt_q;
    logic [TO_W-1:0]   to_q;
    logic              reg_we_q;
    logic              reg_re_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [7:0]        reg_wdata_q;
    logic              err_addr_q;
    logic              err_to_q;
    logic              err_ovr_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    logic              push;
    logic              pop;
    logic [7:0]        push_data;
    logic [ADDR_W-1:0] addr_inc;
    logic              issue_cur;
    logic              issue_inc;
    logic              timeout_hit;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return int'(a) < NREGS;
    endfunction

    function automatic logic slot_free(input logic [OCC_W-1:0] occ);
        return occ < OCC_W'(FIFO_DEPTH);
    endfunction

    assign addr_inc    = addr_q + ADDR_W'(1);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_q == TO_W'(TO_LAST));

    // FIFO pushes come from RD_CAP (captured read data) or RD_REQ (invalid address answered directly).
    always_comb begin
        push      = 1'b0;
        push_data = ERR_BYTE;
        if (state_q == S_RD_CAP) begin
            push      = 1'b1;
            push_data = bus.reg_rdata;
        end else if (state_q == S_RD_REQ && !reg_re_q && !addr_ok(addr_q) && slot_free(occ_q)) begin
            push = 1'b1;
        end
    end

    assign pop   = (occ_q != '0) && bus.tx_ready;
    assign occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

    // reg_re is decided one cycle ahead, so it coincides with the RD_REQ cycle that issues the beat.
    // Requiring a free slot at that point guarantees room for the push in the following RD_CAP.
    assign issue_cur = addr_ok(addr_q) && slot_free(occ_d);
    assign issue_inc = addr_ok(addr_inc) && slot_free(occ_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            err_addr_q  <= 1'b0;
            err_to_q    <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            to_q     <= '0;
            // A clear is issued first so that any set in the same cycle overrides it.
            if (err_clr) begin
                err_addr_q <= 1'b0;
                err_to_q   <= 1'b0;
                err_ovr_q  <= 1'b0;
            end
            if ((state_q == S_RD_REQ || state_q == S_RD_CAP) && bus.rx_valid) err_ovr_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        wr_q    <= bus.rx_data[7];
                        addr_q  <= bus.rx_data[ADDR_W-1:0];
                        state_q <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (bus.rx_valid) begin
                        cnt_q <= bus.rx_data;
                        if (bus.rx_data == 8'd0) begin
                            state_q <= S_IDLE;
                        end else if (wr_q) begin
                            state_q <= S_WDATA;
                        end else begin
                            state_q <= S_RD_REQ;
                            if (issue_cur) begin
                                reg_re_q   <= 1'b1;
                                reg_addr_q <= addr_q;
                            end
                        end
                    end else if (timeout_hit) begin
                        state_q  <= S_IDLE;
                        err_to_q <= 1'b1;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                S_WDATA: begin
                    if (bus.rx_valid) begin
                        if (addr_ok(addr_q)) begin
                            reg_we_q    <= 1'b1;
                            reg_addr_q  <= addr_q;
                            reg_wdata_q <= bus.rx_data;
                        end else begin
                            err_addr_q <= 1'b1;
                        end
                        addr_q <= addr_inc;
                        cnt_q  <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_q <= S_IDLE;
                    end else if (timeout_hit) begin
                        state_q  <= S_IDLE;
                        err_to_q <= 1'b1;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                S_RD_REQ: begin
                    if (reg_re_q) begin
                        state_q <= S_RD_CAP;
                    end else if (push) begin
                        err_addr_q <= 1'b1;
                        addr_q     <= addr_inc;
                        cnt_q      <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_q <= S_IDLE;
                        end else if (issue_inc) begin
                            reg_re_q   <= 1'b1;
                            reg_addr_q <= addr_inc;
                        end
                    end else if (issue_cur) begin
                        reg_re_q   <= 1'b1;
                        reg_addr_q <= addr_q;
                    end
                end
                S_RD_CAP: begin
                    addr_q <= addr_inc;
                    cnt_q  <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RD_REQ;
                        if (issue_inc) begin
                            reg_re_q   <= 1'b1;
                            reg_addr_q <= addr_inc;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_data   = mem_q[rd_ptr_q];
    assign bus.tx_valid  = (occ_q != '0);
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;

    assign busy        = (state_q != S_IDLE);
    assign err_addr    = err_addr_q;
    assign err_timeout = err_to_q;
    assign err_overrun = err_ovr_q;
    assign irq         = err_addr_q | err_to_q | err_ovr_q;
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: a frame-level model predicts register writes, reads, TX bytes and flags.
// The bench also acts as the register file and the UART byte source/sink.
module tb_uart_reg_bridge;
    localparam int AW    = 3;
    localparam int NREGS = 6;
    localparam int DEPTH = 4;
    localparam int TOC   = 20;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic clk;
    logic rst_n;
    logic busy, err_addr, err_timeout, err_overrun, err_clr, irq;

    uart_reg_bridge_if #(.ADDR_W(AW)) bus ();

    uart_reg_bridge #(
        .ADDR_W(AW), .NREGS(NREGS), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TOC), .ERR_BYTE(8'hEE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err_addr(err_addr),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wr_seen  = 0;
    int rd_seen  = 0;

    logic [7:0] env_regs [8];
    logic [7:0] m_regs   [8];
    logic [7:0] wbuf     [16];
    logic       m_err_addr, m_err_to, m_err_ovr;
    logic       hold_rdy;
    wr_t        exp_wr [$];
    logic [AW-1:0] exp_rd [$];
    logic [7:0] exp_tx [$];

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register file responder: reg_rdata is registered, valid the cycle after reg_re.
    always @(posedge clk) begin
        if (bus.reg_we) env_regs[bus.reg_addr] <= bus.reg_wdata;
        if (bus.reg_re) bus.reg_rdata <= env_regs[bus.reg_addr];
    end

    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        wr_t           w;
        logic [AW-1:0] ra;
        logic [7:0]    tb;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.reg_we) begin
                    wr_seen++;
                    check_val("wr_pending", 32'(exp_wr.size() > 0), 1);
                    if (exp_wr.size() > 0) begin
                        w = exp_wr.pop_front();
                        check_val("wr_addr", 32'(bus.reg_addr), 32'(w.a));
                        check_val("wr_data", 32'(bus.reg_wdata), 32'(w.d));
                    end
                end
                if (bus.reg_re) begin
                    rd_seen++;
                    check_val("rd_pending", 32'(exp_rd.size() > 0), 1);
                    if (exp_rd.size() > 0) begin
                        ra = exp_rd.pop_front();
                        check_val("rd_addr", 32'(bus.reg_addr), 32'(ra));
                    end
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    check_val("tx_pending", 32'(exp_tx.size() > 0), 1);
                    if (exp_tx.size() > 0) begin
                        tb = exp_tx.pop_front();
                        check_val("tx_byte", 32'(bus.tx_data), 32'(tb));
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic gap();
        tick($urandom_range(0, 4));
    endtask

    task automatic model_wbeat(input int a, input logic [7:0] d);
        if (a < NREGS) begin
            m_regs[a] = d;
            exp_wr.push_back('{a: AW'(a), d: d});
        end else begin
            m_err_addr = 1'b1;
        end
    endtask

    task automatic model_read(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            int a;
            a = (start + i) % (1 << AW);
            if (a < NREGS) begin
                exp_rd.push_back(AW'(a));
                exp_tx.push_back(m_regs[a]);
            end else begin
                exp_tx.push_back(8'hEE);
                m_err_addr = 1'b1;
            end
        end
    endtask

    task automatic write_frame(input logic [7:0] hdr, input int n);
        send_byte(hdr);
        gap();
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            gap();
            model_wbeat((int'(hdr[AW-1:0]) + i) % (1 << AW), wbuf[i]);
            send_byte(wbuf[i]);
        end
    endtask

    task automatic read_frame(input logic [7:0] hdr, input int n);
        send_byte(hdr);
        gap();
        model_read(int'(hdr[AW-1:0]), n);
        send_byte(8'(n));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || bus.tx_valid || exp_tx.size() != 0) && n < 2000) begin
            tick(1);
            n++;
        end
        if (n >= 2000) check_val("idle_wait_expired", 32'(n), 0);
        tick(1);
    endtask

    task automatic check_flags(input string tag);
        check_val({tag, "_err_addr"}, 32'(err_addr), 32'(m_err_addr));
        check_val({tag, "_err_timeout"}, 32'(err_timeout), 32'(m_err_to));
        check_val({tag, "_err_overrun"}, 32'(err_overrun), 32'(m_err_ovr));
        check_val({tag, "_irq"}, 32'(irq), 32'(m_err_addr | m_err_to | m_err_ovr));
        check_val({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_err_addr = 1'b0;
        m_err_to   = 1'b0;
        m_err_ovr  = 1'b0;
    endtask

    task automatic random_frame();
        logic       wr;
        int         start, n;
        logic [7:0] hdr;
        wr    = 1'($urandom_range(0, 1));
        start = $urandom_range(0, 7);
        n     = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, ($urandom_range(0, 3) == 0) ? 12 : 5);
        hdr   = {wr, 4'($urandom), 3'(start)};
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        if (wr) write_frame(hdr, n);
        else    read_frame(hdr, n);
        wait_idle();
        check_flags("rand");
        if ($urandom_range(0, 3) == 0) clear_flags();
    endtask

    initial begin
        int k, rd0, wr0;
        rst_n        = 1'b0;
        err_clr      = 1'b0;
        hold_rdy     = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.reg_rdata = 8'h00;
        m_err_addr = 1'b0;
        m_err_to   = 1'b0;
        m_err_ovr  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            env_regs[i] = 8'($urandom);
            m_regs[i]   = env_regs[i];
        end
        tick(3);
        check_val("rst_tx_valid", 32'(bus.tx_valid), 0);
        check_val("rst_reg_we", 32'(bus.reg_we), 0);
        check_val("rst_reg_re", 32'(bus.reg_re), 0);
        check_val("rst_reg_addr", 32'(bus.reg_addr), 0);
        check_val("rst_reg_wdata", 32'(bus.reg_wdata), 0);
        check_val("rst_irq", 32'(irq), 0);
        check_flags("rst");
        rst_n = 1'b1;
        tick(2);

        // Write burst 2,3,4 then read it back
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC;
        write_frame(8'h82, 3);
        wait_idle();
        check_flags("wburst");
        read_frame(8'h02, 3);
        wait_idle();
        check_flags("rback");

        // Read burst with backpressure: 6,7 invalid, 0,1 read, addr 2 waits for a slot
        hold_rdy = 1'b1;
        tick(2);
        rd0 = rd_seen;
        read_frame(8'h06, 5);
        tick(40);
        check_val("bp_reads_before_full", 32'(rd_seen - rd0), 2);
        check_val("bp_busy_waiting", 32'(busy), 1);
        check_val("bp_tx_valid", 32'(bus.tx_valid), 1);
        check_val("bp_nothing_popped", 32'(exp_tx.size()), 5);
        hold_rdy = 1'b0;
        wait_idle();
        check_val("bp_reads_total", 32'(rd_seen - rd0), 3);
        check_flags("bp");
        clear_flags();
        check_flags("bp_clr");

        // Invalid tail of a read burst, then clear
        read_frame(8'h05, 2);
        wait_idle();
        check_flags("inval");
        clear_flags();
        check_flags("inval_clr");

        // Set wins over a simultaneous clear
        wbuf[0] = 8'h55;
        send_byte(8'h87);
        send_byte(8'h01);
        model_wbeat(7, wbuf[0]);
        err_clr = 1'b1;
        send_byte(wbuf[0]);
        err_clr = 1'b0;
        wait_idle();
        check_flags("set_vs_clr");
        clear_flags();

        // Timeout after one data byte of a two-beat write
        wr0 = wr_seen;
        send_byte(8'h81);
        send_byte(8'h02);
        model_wbeat(1, 8'h3C);
        send_byte(8'h3C);
        k = 0;
        while (!err_timeout && k < 100) begin
            tick(1);
            k++;
        end
        m_err_to = 1'b1;
        check_val("to_latency", 32'(k), TOC);
        check_val("to_writes", 32'(wr_seen - wr0), 1);
        check_flags("to");
        clear_flags();

        // Overrun: byte during a read is dropped, burst completes intact
        send_byte(8'h00);
        model_read(0, 3);
        send_byte(8'h03);
        send_byte(8'h81);
        m_err_ovr = 1'b1;
        wait_idle();
        check_flags("ovr");
        clear_flags();

        // CNT 0: no strobes
        wr0 = wr_seen;
        rd0 = rd_seen;
        send_byte(8'h83);
        send_byte(8'h00);
        tick(3);
        check_val("cnt0_strobes", 32'((wr_seen - wr0) + (rd_seen - rd0)), 0);
        check_flags("cnt0");

        // Asynchronous reset in the middle of a stalled read burst
        hold_rdy = 1'b1;
        tick(2);
        read_frame(8'h00, 6);
        tick(8);
        check_val("prerst_tx_valid", 32'(bus.tx_valid), 1);
        check_val("prerst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_tx_valid", 32'(bus.tx_valid), 0);
        check_val("midrst_busy", 32'(busy), 0);
        check_val("midrst_reg_re", 32'(bus.reg_re), 0);
        exp_tx.delete();
        exp_rd.delete();
        exp_wr.delete();
        m_err_addr = 1'b0;
        m_err_to   = 1'b0;
        m_err_ovr  = 1'b0;
        tick(2);
        rst_n    = 1'b1;
        hold_rdy = 1'b0;
        tick(4);
        check_val("postrst_tx_valid", 32'(bus.tx_valid), 0);
        check_flags("postrst");

        for (int f = 0; f < 40; f++) random_frame();

        check_val("end_exp_wr_empty", 32'(exp_wr.size()), 0);
        check_val("end_exp_rd_empty", 32'(exp_rd.size()), 0);
        check_val("end_exp_tx_empty", 32'(exp_tx.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end
endmodule
